// File: rtl/twobyone_rr_arbiter.sv
// twobyone_rr_arbiter
// Packet-aware round-robin arbiter that shares one n-bit output stream
// between two valid/ready requesters. A grant is held from the first beat
// of a packet until its last beat is accepted, so packets never interleave.
// The granted requester's beat goes through a 2:1 select and is registered
// into a one-entry output stage.
//
// Ports:
//   in_clk, in_rst         clock (rising edge), async active-high reset
//   in_valid_one/_two      requester has a beat
//   in_data_one/_two       requester beat data (n bits)
//   in_last_one/_two       beat is the last of its packet
//   out_ready_one/_two     requester beat accepted when high with its valid
//   out_valid/data/last    registered output beat
//   in_ready               downstream accepts the output beat
//   out_sel                mux select: 0 = requester one, 1 = requester two
//   out_busy               a grant is active
module twobyone_rr_arbiter #(
  parameter int n = 8
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_valid_one,
  input  logic [n-1:0] in_data_one,
  input  logic         in_last_one,
  output logic         out_ready_one,
  input  logic         in_valid_two,
  input  logic [n-1:0] in_data_two,
  input  logic         in_last_two,
  output logic         out_ready_two,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  output logic         out_last,
  input  logic         in_ready,
  output logic         out_sel,
  output logic         out_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_ONE = 2'd1,
    GRANT_TWO = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         r_last_served;      // 0 = one, 1 = two
  logic         w_last_served_next;
  logic         r_valid;
  logic [n-1:0] r_data;
  logic         r_last;

  logic         w_stage_free;
  logic         w_acc_one;
  logic         w_acc_two;
  logic         w_acc;
  logic [n-1:0] w_sel_data;
  logic         w_sel_last;

  // Select and busy are pure decodes of the state register.
  assign out_sel  = (r_state == GRANT_TWO);
  assign out_busy = (r_state == GRANT_ONE) || (r_state == GRANT_TWO);

  // The output stage can take a new beat if it is empty or draining now.
  assign w_stage_free  = !r_valid || in_ready;
  assign out_ready_one = (r_state == GRANT_ONE) && w_stage_free;
  assign out_ready_two = (r_state == GRANT_TWO) && w_stage_free;

  assign w_acc_one = out_ready_one && in_valid_one;
  assign w_acc_two = out_ready_two && in_valid_two;
  assign w_acc     = w_acc_one || w_acc_two;

  // 2:1 data mux driven by the registered select.
  assign w_sel_data = out_sel ? in_data_two : in_data_one;
  assign w_sel_last = out_sel ? in_last_two : in_last_one;

  always_comb begin
    w_state_next       = r_state;
    w_last_served_next = r_last_served;
    case (r_state)
      IDLE: begin
        // Grant only; nothing is accepted in this cycle.
        if (in_valid_one && in_valid_two) begin
          w_state_next = r_last_served ? GRANT_ONE : GRANT_TWO;
        end else if (in_valid_one) begin
          w_state_next = GRANT_ONE;
        end else if (in_valid_two) begin
          w_state_next = GRANT_TWO;
        end
      end
      GRANT_ONE: begin
        if (w_acc_one && in_last_one) begin
          w_last_served_next = 1'b0;
          // Hand straight to the other side if it waits; otherwise idle,
          // even if requester one still has data (one-cycle bubble).
          w_state_next = in_valid_two ? GRANT_TWO : IDLE;
        end
      end
      GRANT_TWO: begin
        if (w_acc_two && in_last_two) begin
          w_last_served_next = 1'b1;
          w_state_next = in_valid_one ? GRANT_ONE : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state       <= IDLE;
      r_last_served <= 1'b1;   // two was "last served" so one wins first tie
    end else begin
      r_state       <= w_state_next;
      r_last_served <= w_last_served_next;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
      r_last  <= w_sel_last;
    end else if (in_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_last  = r_last;

endmodule

// File: tb/tb_twobyone_rr_arbiter.sv
module tb_twobyone_rr_arbiter;

  logic       in_clk;
  logic       in_rst;
  logic       in_valid_one;
  logic [7:0] in_data_one;
  logic       in_last_one;
  logic       out_ready_one;
  logic       in_valid_two;
  logic [7:0] in_data_two;
  logic       in_last_two;
  logic       out_ready_two;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       in_ready;
  logic       out_sel;
  logic       out_busy;

  twobyone_rr_arbiter #(.n(8)) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_valid_one (in_valid_one),
    .in_data_one  (in_data_one),
    .in_last_one  (in_last_one),
    .out_ready_one(out_ready_one),
    .in_valid_two (in_valid_two),
    .in_data_two  (in_data_two),
    .in_last_two  (in_last_two),
    .out_ready_two(out_ready_two),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .in_ready     (in_ready),
    .out_sel      (out_sel),
    .out_busy     (out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  // Requester sources: a queue of pending beats plus an enable.
  beat_t q1[$];
  beat_t q2[$];
  bit    en1, en2;
  bit    pend1, pend2;

  // Reference model: who owns the stream, who was served last,
  // and the one-entry output stage contents.
  int         m_owner;   // 0 none, 1 requester one, 2 requester two
  int         m_ls;      // 1 or 2
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_ol;

  logic [7:0] seen[$];
  bit         verbose;
  int         n_assert;
  int         n_fail;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_seen(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, 8'(seen.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk(tag, seen[i], exp[i]);
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (k == 1) q1.push_back(b);
    else        q2.push_back(b);
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_ls    = 2;
    m_ov    = 1'b0;
    m_od    = 8'h00;
    m_ol    = 1'b0;
    q1.delete();
    q2.delete();
    en1 = 0; en2 = 0;
    pend1 = 0; pend2 = 0;
    seen.delete();
  endtask

  task automatic apply_reset();
    in_rst = 1'b1;
    in_valid_one = 1'b0;
    in_valid_two = 1'b0;
    model_reset();
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, step model.
  task automatic cycle();
    logic e_rdy1, e_rdy2, acc1, acc2, stage_free;
    in_valid_one = en1 && (q1.size() > 0);
    if (in_valid_one) begin
      in_data_one = q1[0].d;
      in_last_one = q1[0].l;
    end else begin
      in_data_one = 8'($urandom);
      in_last_one = 1'($urandom);
    end
    in_valid_two = en2 && (q2.size() > 0);
    if (in_valid_two) begin
      in_data_two = q2[0].d;
      in_last_two = q2[0].l;
    end else begin
      in_data_two = 8'($urandom);
      in_last_two = 1'($urandom);
    end
    @(negedge in_clk);
    stage_free = !m_ov || in_ready;
    e_rdy1 = (m_owner == 1) && stage_free;
    e_rdy2 = (m_owner == 2) && stage_free;
    chk("ready_one", {7'b0, out_ready_one}, {7'b0, e_rdy1});
    chk("ready_two", {7'b0, out_ready_two}, {7'b0, e_rdy2});
    chk("out_valid", {7'b0, out_valid}, {7'b0, m_ov});
    chk("out_data",  out_data, m_od);
    chk("out_last",  {7'b0, out_last}, {7'b0, m_ol});
    chk("out_sel",   {7'b0, out_sel}, {7'b0, (m_owner == 2)});
    chk("out_busy",  {7'b0, out_busy}, {7'b0, (m_owner != 0)});
    if (out_valid === 1'b1 && in_ready) begin
      seen.push_back(out_data);
      if (verbose) $display("t=%0t out beat data=%h last=%b sel=%b", $time, out_data, out_last, out_sel);
    end
    acc1 = e_rdy1 && in_valid_one;
    acc2 = e_rdy2 && in_valid_two;
    if (acc1 || acc2) begin
      m_ov = 1'b1;
      m_od = acc1 ? q1[0].d : q2[0].d;
      m_ol = acc1 ? q1[0].l : q2[0].l;
    end else if (in_ready) begin
      m_ov = 1'b0;
    end
    if (m_owner == 0) begin
      if (in_valid_one && in_valid_two) m_owner = (m_ls == 2) ? 1 : 2;
      else if (in_valid_one)            m_owner = 1;
      else if (in_valid_two)            m_owner = 2;
    end else if (acc1 && q1[0].l) begin
      m_ls = 1;
      m_owner = in_valid_two ? 2 : 0;
    end else if (acc2 && q2[0].l) begin
      m_ls = 2;
      m_owner = in_valid_one ? 1 : 0;
    end
    pend1 = in_valid_one && !acc1;
    pend2 = in_valid_two && !acc2;
    if (acc1) void'(q1.pop_front());
    if (acc2) void'(q2.pop_front());
    @(posedge in_clk);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  initial begin
    logic [7:0] exp[$];
    n_assert = 0;
    n_fail   = 0;
    verbose  = 1;
    in_rst   = 1'b1;
    in_ready = 1'b1;
    in_valid_one = 0; in_data_one = 0; in_last_one = 0;
    in_valid_two = 0; in_data_two = 0; in_last_two = 0;
    #2;

    // 1: single requester, 3-beat packet
    apply_reset();
    run(1);
    push_beat(1, 8'h11, 0); push_beat(1, 8'h12, 0); push_beat(1, 8'h13, 1);
    en1 = 1;
    run(7);
    exp = '{8'h11, 8'h12, 8'h13};
    chk_seen("t1_order", exp);
    chk("t1_idle", {7'b0, out_busy}, 8'h00);

    // 2: both requesters tie from reset
    apply_reset();
    push_beat(1, 8'hA0, 0); push_beat(1, 8'hA1, 1);
    push_beat(2, 8'hB0, 0); push_beat(2, 8'hB1, 1);
    en1 = 1; en2 = 1;
    run(8);
    exp = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
    chk_seen("t2_order", exp);

    // 3: two served last, then a tie goes to one
    apply_reset();
    push_beat(2, 8'h55, 1);
    en2 = 1;
    run(4);
    push_beat(1, 8'h31, 1);
    push_beat(2, 8'h32, 1);
    en1 = 1;
    run(1);
    chk("t3_sel_one", {7'b0, out_sel}, 8'h00);
    chk("t3_busy", {7'b0, out_busy}, 8'h01);
    run(6);
    exp = '{8'h55, 8'h31, 8'h32};
    chk_seen("t3_order", exp);

    // 4: downstream backpressure
    apply_reset();
    push_beat(1, 8'h77, 0); push_beat(1, 8'h78, 1);
    en1 = 1;
    run(2);
    in_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold", out_data, 8'h77);
      chk("t4_ready_one", {7'b0, out_ready_one}, 8'h00);
    end
    in_ready = 1;
    run(4);
    exp = '{8'h77, 8'h78};
    chk_seen("t4_order", exp);

    // 5: asynchronous reset mid-packet
    apply_reset();
    push_beat(1, 8'h21, 0); push_beat(1, 8'h22, 0); push_beat(1, 8'h23, 1);
    en1 = 1;
    run(2);
    #2;
    in_rst = 1'b1;
    #1;
    chk("t5_valid", {7'b0, out_valid}, 8'h00);
    chk("t5_busy",  {7'b0, out_busy}, 8'h00);
    chk("t5_sel",   {7'b0, out_sel}, 8'h00);
    model_reset();
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    push_beat(1, 8'h51, 1);
    push_beat(2, 8'h61, 1);
    en1 = 1; en2 = 1;
    run(1);
    chk("t5_tie_sel", {7'b0, out_sel}, 8'h00);
    run(5);
    exp = '{8'h51, 8'h61};
    chk_seen("t5_order", exp);

    // 6: requester one pauses mid-packet, grant is kept
    apply_reset();
    push_beat(1, 8'h81, 0); push_beat(1, 8'h82, 0); push_beat(1, 8'h83, 1);
    push_beat(2, 8'h91, 1);
    en1 = 1; en2 = 1;
    run(2);
    en1 = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t6_sel", {7'b0, out_sel}, 8'h00);
      chk("t6_ready_two", {7'b0, out_ready_two}, 8'h00);
    end
    en1 = 1;
    run(7);
    exp = '{8'h81, 8'h82, 8'h83, 8'h91};
    chk_seen("t6_order", exp);

    // Random traffic against the model
    verbose = 0;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 1; k <= 2; k++) begin
        int qs;
        qs = (k == 1) ? q1.size() : q2.size();
        if (qs < 3 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push_beat(k, 8'($urandom), (b == len - 1));
        end
      end
      if (!pend1) en1 = ($urandom_range(0, 3) != 0);
      if (!pend2) en2 = ($urandom_range(0, 3) != 0);
      in_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/twobyone_rr_arbiter.md
Name: twobyone_rr_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one n-bit output stream between two valid/ready requesters.
- Drives the select of the team's parameterised 2:1 mux, exported as out_sel, and registers the muxed beat into a one-entry output stage.
- A grant is held from a packet's first beat until its last beat is accepted, so packets from the two requesters never interleave.

Parameters:
n, 8, data width of each requester and of the output stream

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  asynchronous, active-high reset
in_valid_one  input  1  requester one has a beat
in_data_one  input  n  requester one beat data
in_last_one  input  1  beat is last of requester one packet
out_ready_one  output  1  requester one beat accepted this cycle when high with in_valid_one
in_valid_two  input  1  requester two has a beat
in_data_two  input  n  requester two beat data
in_last_two  input  1  beat is last of requester two packet
out_ready_two  output  1  requester two beat accepted this cycle when high with in_valid_two
out_valid  output  1  output stage holds a beat
out_data  output  n  output beat data
out_last  output  1  output beat is last of packet
in_ready  input  1  downstream accepts output beat
out_sel  output  1  mux select: 0 = requester one, 1 = requester two
out_busy  output  1  a grant is active

Behaviour:
- Reset (asynchronous, active-high, in_rst): takes effect immediately, including mid-packet; any in-flight beat is discarded.
  - State goes to IDLE; out_valid, out_data, out_last, out_sel and out_busy all go to 0.
  - last_served is set to two, so requester one wins the first tie.
- State machine: IDLE, GRANT_ONE, GRANT_TWO (registered).
- out_sel = 1 only in GRANT_TWO. out_busy = 1 in either GRANT state. Both are decoded from the state register.
- Ready, combinational: out_ready_k = (state == GRANT_k) && (!out_valid || in_ready). Ready is always 0 in IDLE.
- Accept: requester k's beat is accepted when out_ready_k && in_valid_k.
- Output stage:
  - On accept: out_data <= selected data, out_last <= selected last, out_valid <= 1.
  - Otherwise, if in_ready: out_valid <= 0.
  - Otherwise: hold all values.
  - Latency is 1 cycle from accept to out_valid.
  - Full throughput while in_ready stays high; the output beat is stable while out_valid && !in_ready.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: go to GRANT of that requester.
  - Both valid: grant the requester that is not last_served.
  - No beat is accepted in the IDLE cycle, so there is a one-cycle grant latency.
- GRANT_k:
  - Stay in GRANT_k until a beat with last = 1 is accepted.
  - In_valid_k dropping mid-packet does not release the grant; there is no timeout.
- On acceptance of the last beat: last_served <= k, then:
  - If the other requester's valid is high, go directly to its GRANT state (no bubble).
  - Otherwise go to IDLE, even if requester k is still valid; it is re-granted after a one-cycle bubble.
- A single-beat packet (last = 1 on the first beat) is accepted and released in the same cycle.
- Requester data and last are don't-care while its valid is low. Requesters must hold data stable while valid && !ready.

Test Plan:
1. Reset, then only requester one sends 3 beats (0x11, 0x12, 0x13, last on 0x13) with in_ready = 1. Required: out_sel = 0; out_valid high on consecutive cycles with 0x11, 0x12, 0x13, starting 2 cycles after in_valid_one rises; out_last only with 0x13; state then returns to IDLE.
2. Both requesters valid from reset, each with 2-beat packets (one: 0xA0, 0xA1; two: 0xB0, 0xB1). Required: output order A0, A1, B0, B1; out_sel switches 0 -> 1 with no idle cycle between packets.
3. Requester two sends a 1-beat packet 0x55, then both request. Required: requester one wins the next grant, because two was last_served.
4. Downstream backpressure: in_ready = 0 for 3 cycles while out_valid = 1 with 0x77. Required: out_data holds 0x77, out_ready_one stays 0 and no beat is lost; transfer resumes the cycle after in_ready = 1.
5. Assert in_rst mid-packet after 1 of 3 beats. Required: out_valid, out_busy and out_sel drop to 0 immediately (asynchronously). After release, requester one is granted first on a tie.
6. Requester one deasserts in_valid_one for 2 cycles mid-packet while requester two is valid. Required: the grant stays with one (out_sel = 0, out_ready_two = 0) until one's last beat is accepted.
